// File: rtl/date_value_checker.sv
// Calendar checker that runs alongside the date format checker. It decodes year, month and
// day from the character stream and registers a verdict one cycle after fmt_valid.
// Optional: define DATE_OK_COUNT_EN to add the ok_count accepted-date counter.

module date_value_checker #(
   parameter int YEAR_W = 14
`ifdef DATE_OK_COUNT_EN
   , parameter int CNT_W = 16
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        in,
   input  logic              fmt_valid,
   output logic              out_valid,
   output logic              date_ok,
   output logic [YEAR_W-1:0] year,
   output logic [3:0]        month,
   output logic [4:0]        day,
   output logic              leap
`ifdef DATE_OK_COUNT_EN
   , output logic [CNT_W-1:0] ok_count
`endif
);

   typedef enum logic [1:0] {YEAR, MONTH, DAY} state_t;

   localparam logic [YEAR_W-1:0] YMAX = '1;

   // Year residues are kept with repeated conditional subtraction instead of a divider.
   function automatic logic [6:0] mod100_step(input logic [6:0] old, input logic [3:0] d);
      logic [9:0] x;
      x = {3'd0, old} * 10'd10 + {6'd0, d};
      for (int i = 0; i < 9; i++)
         if (x >= 10'd100) x = x - 10'd100;
      return x[6:0];
   endfunction

   function automatic logic [8:0] mod400_step(input logic [8:0] old, input logic [3:0] d);
      logic [11:0] x;
      x = {3'd0, old} * 12'd10 + {8'd0, d};
      for (int i = 0; i < 9; i++)
         if (x >= 12'd400) x = x - 12'd400;
      return x[8:0];
   endfunction

   function automatic logic [4:0] days_in_month(input logic [6:0] m, input logic lp);
      case (m)
         7'd2:                      return lp ? 5'd29 : 5'd28;
         7'd4, 7'd6, 7'd9, 7'd11:   return 5'd30;
         default:                   return 5'd31;
      endcase
   endfunction

   state_t            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [YEAR_W-1:0] yacc_q, yacc_d;
   logic              yovf_q, yovf_d;
   logic [1:0]        m4_q, m4_d;
   logic [6:0]        m100_q, m100_d;
   logic [8:0]        m400_q, m400_d;
   logic [6:0]        macc_q, macc_d;
   logic [6:0]        dacc_q, dacc_d;
   logic [7:0]        sep_q, sep_d;

   logic              is_digit, is_sep, clear;
   logic [3:0]        dig;
   logic [YEAR_W+3:0] y_raw;
   logic              y_over;
   logic [6:0]        m_next;
   logic [10:0]       cd;
   logic              leap_c, ok_c;

   assign is_digit = (in >= 8'h30) && (in <= 8'h39);
   assign is_sep   = (in == 8'h2e) || (in == 8'h2f) || (in == 8'h2d);
   assign dig      = is_digit ? in[3:0] : 4'd0;
   assign y_raw    = {4'd0, yacc_q} * (YEAR_W+4)'(10) + {{YEAR_W{1'b0}}, dig};
   assign y_over   = y_raw > {4'd0, YMAX};
   assign m_next   = macc_q * 7'd10 + {3'd0, dig};

   // Candidate day includes the digit on the bus, so 1- and 2-digit matches both evaluate.
   assign cd     = {4'd0, dacc_q} * 11'd10 + {7'd0, dig};
   assign leap_c = ((m4_q == 2'd0) && (m100_q != 7'd0)) || (m400_q == 9'd0);
   assign ok_c   = (state_q == DAY) && !yovf_q &&
                   (macc_q >= 7'd1) && (macc_q <= 7'd12) &&
                   (cd >= 11'd1) && (cd <= {6'd0, days_in_month(macc_q, leap_c)});

   always_comb begin
      // NOTE: every signal written here gets a default first, so no latch can be inferred.
      state_d = state_q;
      cnt_d   = cnt_q;
      yacc_d  = yacc_q;
      yovf_d  = yovf_q;
      m4_d    = m4_q;
      m100_d  = m100_q;
      m400_d  = m400_q;
      macc_d  = macc_q;
      dacc_d  = dacc_q;
      sep_d   = sep_q;
      clear   = 1'b0;

      if (is_digit) begin
         cnt_d = (cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1;
         case (state_q)
            YEAR: begin
               if (yovf_q || y_over) begin
                  yacc_d = YMAX;
                  yovf_d = 1'b1;
               end else begin
                  yacc_d = y_raw[YEAR_W-1:0];
               end
               m4_d   = {m4_q[0], 1'b0} + dig[1:0];
               m100_d = mod100_step(m100_q, dig);
               m400_d = mod400_step(m400_q, dig);
            end
            MONTH:   macc_d = m_next;
            DAY:     dacc_d = cd[6:0];
            default: clear  = 1'b1;
         endcase
      end else if (is_sep) begin
         case (state_q)
            YEAR: begin
               if (cnt_q >= 3'd4) begin
                  sep_d   = in;
                  state_d = MONTH;
                  macc_d  = 7'd0;
                  cnt_d   = 3'd0;
               end else begin
                  clear = 1'b1;
               end
            end
            MONTH: begin
               if ((in == sep_q) && (cnt_q >= 3'd1) && (cnt_q <= 3'd2)) begin
                  state_d = DAY;
                  dacc_d  = 7'd0;
                  cnt_d   = 3'd0;
               end else begin
                  clear = 1'b1;
               end
            end
            default: clear = 1'b1;
         endcase
      end else begin
         clear = 1'b1;
      end

      if (clear) begin
         state_d = YEAR;
         cnt_d   = 3'd0;
         yacc_d  = '0;
         yovf_d  = 1'b0;
         m4_d    = 2'd0;
         m100_d  = 7'd0;
         m400_d  = 9'd0;
         macc_d  = 7'd0;
         dacc_d  = 7'd0;
         sep_d   = 8'd0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= YEAR;
         cnt_q   <= 3'd0;
         yacc_q  <= '0;
         yovf_q  <= 1'b0;
         m4_q    <= 2'd0;
         m100_q  <= 7'd0;
         m400_q  <= 9'd0;
         macc_q  <= 7'd0;
         dacc_q  <= 7'd0;
         sep_q   <= 8'd0;
      end else begin
         // NOTE: non-blocking so every register samples the values from before the edge.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         yacc_q  <= yacc_d;
         yovf_q  <= yovf_d;
         m4_q    <= m4_d;
         m100_q  <= m100_d;
         m400_q  <= m400_d;
         macc_q  <= macc_d;
         dacc_q  <= dacc_d;
         sep_q   <= sep_d;
      end
   end

   // Report stage: fields hold their last reported values between pulses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         date_ok   <= 1'b0;
         year      <= '0;
         month     <= 4'd0;
         day       <= 5'd0;
         leap      <= 1'b0;
      end else begin
         out_valid <= fmt_valid;
         if (fmt_valid) begin
            date_ok <= ok_c;
            year    <= yacc_q;
            month   <= macc_q[3:0];
            day     <= cd[4:0];
            leap    <= leap_c;
         end
      end
   end

`ifdef DATE_OK_COUNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         ok_count <= '0;
      else if (out_valid && date_ok)
         ok_count <= ok_count + CNT_W'(1);
   end
`endif

endmodule

// File: tb/tb_date_value_checker.sv
// Self-checking bench for date_value_checker: directed calendar cases plus a randomized
// character stream compared against a field-queue reference model.

module tb_date_value_checker;

   localparam int     YEAR_W = 14;
   localparam longint YMAX   = (64'd1 << YEAR_W) - 1;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [7:0]        in = 8'h20;
   logic              fmt_valid = 1'b0;
   logic              out_valid, date_ok, leap;
   logic [YEAR_W-1:0] year;
   logic [3:0]        month;
   logic [4:0]        day;
`ifdef DATE_OK_COUNT_EN
   logic [15:0]       ok_count;
`endif

   date_value_checker #(.YEAR_W(YEAR_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in        (in),
      .fmt_valid (fmt_valid),
      .out_valid (out_valid),
      .date_ok   (date_ok),
      .year      (year),
      .month     (month),
      .day       (day),
      .leap      (leap)
`ifdef DATE_OK_COUNT_EN
      , .ok_count (ok_count)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: the digits of each field are kept as plain queues.
   typedef enum {M_YEAR, M_MONTH, M_DAY} mstate_t;
   mstate_t ms;
   int      yq[$];
   int      mq[$];
   int      dq[$];
   byte     msep;
   bit      e_valid, e_ok, e_leap;
   longint  e_year;
   int      e_month, e_day, e_cnt;
   byte     chars[$];

   function automatic bit is_dig(byte c);
      return (c >= "0") && (c <= "9");
   endfunction

   function automatic bit is_sepc(byte c);
      return (c == ".") || (c == "/") || (c == "-");
   endfunction

   function automatic void model_clear();
      yq.delete();
      mq.delete();
      dq.delete();
      ms   = M_YEAR;
      msep = 0;
   endfunction

   function automatic void model_reset();
      model_clear();
      e_valid = 0; e_ok = 0; e_leap = 0;
      e_year = 0; e_month = 0; e_day = 0; e_cnt = 0;
   endfunction

   function automatic void model_step(byte c, bit fv);
      int dmt[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
      longint yv = 0;
      bit     yo = 0;
      bit     lp;
      int     r400 = 0, mv = 0, dv = 0, cd, dim;
      e_valid = fv;
      if (fv) begin
         foreach (yq[i]) begin
            if (!yo) begin
               yv = yv * 10 + yq[i];
               if (yv > YMAX) begin yo = 1; yv = YMAX; end
            end
            r400 = (r400 * 10 + yq[i]) % 400;
         end
         lp = ((r400 % 4 == 0) && (r400 % 100 != 0)) || (r400 == 0);
         foreach (mq[i]) mv = (mv * 10 + mq[i]) % 128;
         foreach (dq[i]) dv = (dv * 10 + dq[i]) % 128;
         cd  = dv * 10 + (is_dig(c) ? int'(c) - 48 : 0);
         dim = (mv >= 1 && mv <= 12) ? dmt[mv-1] + ((mv == 2 && lp) ? 1 : 0) : 0;
         e_ok    = (ms == M_DAY) && !yo && (cd >= 1) && (cd <= dim);
         e_year  = yv;
         e_month = mv % 16;
         e_day   = cd % 32;
         e_leap  = lp;
         if (e_ok) e_cnt++;
      end
      if (is_dig(c)) begin
         case (ms)
            M_YEAR:  yq.push_back(int'(c) - 48);
            M_MONTH: mq.push_back(int'(c) - 48);
            default: dq.push_back(int'(c) - 48);
         endcase
      end else if (is_sepc(c)) begin
         if (ms == M_YEAR && yq.size() >= 4) begin
            ms = M_MONTH; msep = c; mq.delete();
         end else if (ms == M_MONTH && c == msep && mq.size() >= 1 && mq.size() <= 2) begin
            ms = M_DAY; dq.delete();
         end else begin
            model_clear();
         end
      end else begin
         model_clear();
      end
   endfunction

   task automatic send(input byte c, input bit fv);
      in        = c;
      fmt_valid = fv;
      model_step(c, fv);
      @(posedge clk);
      #1;
   endtask

   task automatic send_str(input string s, input int nfv);
      for (int i = 0; i < s.len(); i++)
         send(s[i], i >= s.len() - nfv);
      fmt_valid = 1'b0;
   endtask

   task automatic push_num(input int v, input int nd);
      int p = 1;
      for (int i = 1; i < nd; i++) p *= 10;
      for (int i = 0; i < nd; i++) begin
         chars.push_back(byte'(48 + (v / p) % 10));
         p /= 10;
      end
   endtask

   task automatic test_reset();
      model_reset();
      #3;
      for (int k = 0; k < 3; k++) begin
         checks += 6;
         if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b want 0", out_valid); end
         if (date_ok !== 1'b0)   begin errors++; $display("FAIL reset date_ok got %b want 0", date_ok); end
         if (year !== '0)        begin errors++; $display("FAIL reset year got %0d want 0", year); end
         if (month !== 4'd0)     begin errors++; $display("FAIL reset month got %0d want 0", month); end
         if (day !== 5'd0)       begin errors++; $display("FAIL reset day got %0d want 0", day); end
         if (leap !== 1'b0)      begin errors++; $display("FAIL reset leap got %b want 0", leap); end
         in = "5"; fmt_valid = 1'b1;
         @(posedge clk); #1;
      end
      fmt_valid = 1'b0; in = " ";
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   typedef struct {string s; int y; int m; int d; bit ok; bit lp;} dcase_t;

   task automatic test_directed();
      dcase_t tbl[$];
      tbl.push_back(dcase_t'{" 2020-2-29", 2020,  2, 29, 1'b1, 1'b1});
      tbl.push_back(dcase_t'{" 2021-2-29", 2021,  2, 29, 1'b0, 1'b0});
      tbl.push_back(dcase_t'{" 1900.2.29", 1900,  2, 29, 1'b0, 1'b0});
      tbl.push_back(dcase_t'{" 2000.2.29", 2000,  2, 29, 1'b1, 1'b1});
      tbl.push_back(dcase_t'{" 2021/4/31", 2021,  4, 31, 1'b0, 1'b0});
      tbl.push_back(dcase_t'{" 2021/4/30", 2021,  4, 30, 1'b1, 1'b0});
      tbl.push_back(dcase_t'{" 2021/13/1", 2021, 13,  1, 1'b0, 1'b0});
      tbl.push_back(dcase_t'{" 99999/1/1", 16383, 1,  1, 1'b0, 1'b0});
      tbl.push_back(dcase_t'{" 2024/1",    2024,  0,  1, 1'b0, 1'b1});
      foreach (tbl[i]) begin
         send_str(tbl[i].s, 1);
         checks += 6;
         if (out_valid !== 1'b1) begin errors++; $display("FAIL dir%0d out_valid got %b want 1", i, out_valid); end
         if (year !== YEAR_W'(tbl[i].y)) begin errors++; $display("FAIL dir%0d year got %0d want %0d", i, year, tbl[i].y); end
         if (month !== 4'(tbl[i].m)) begin errors++; $display("FAIL dir%0d month got %0d want %0d", i, month, tbl[i].m); end
         if (day !== 5'(tbl[i].d))   begin errors++; $display("FAIL dir%0d day got %0d want %0d", i, day, tbl[i].d); end
         if (date_ok !== tbl[i].ok)  begin errors++; $display("FAIL dir%0d date_ok got %b want %b", i, date_ok, tbl[i].ok); end
         if (leap !== tbl[i].lp)     begin errors++; $display("FAIL dir%0d leap got %b want %b", i, leap, tbl[i].lp); end
      end
   endtask

   task automatic test_back_to_back();
      send_str(" 2021/12/", 0);
      send("2", 1'b1);
      checks += 5;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b first out_valid got %b want 1", out_valid); end
      if (day !== 5'd2)       begin errors++; $display("FAIL b2b first day got %0d want 2", day); end
      if (date_ok !== 1'b1)   begin errors++; $display("FAIL b2b first date_ok got %b want 1", date_ok); end
      if (year !== YEAR_W'(2021)) begin errors++; $display("FAIL b2b first year got %0d want 2021", year); end
      if (month !== 4'd12)    begin errors++; $display("FAIL b2b first month got %0d want 12", month); end
      send("5", 1'b1);
      checks += 6;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b second out_valid got %b want 1", out_valid); end
      if (year !== YEAR_W'(2021)) begin errors++; $display("FAIL b2b second year got %0d want 2021", year); end
      if (month !== 4'd12)    begin errors++; $display("FAIL b2b second month got %0d want 12", month); end
      if (day !== 5'd25)      begin errors++; $display("FAIL b2b second day got %0d want 25", day); end
      if (date_ok !== 1'b1)   begin errors++; $display("FAIL b2b second date_ok got %b want 1", date_ok); end
      if (leap !== 1'b0)      begin errors++; $display("FAIL b2b second leap got %b want 0", leap); end
      send(" ", 1'b0);
      checks += 3;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL hold out_valid got %b want 0", out_valid); end
      if (day !== 5'd25)      begin errors++; $display("FAIL hold day got %0d want 25", day); end
      if (date_ok !== 1'b1)   begin errors++; $display("FAIL hold date_ok got %b want 1", date_ok); end
   endtask

   task automatic test_mid_reset();
      send_str(" 2021/1", 0);
      #2 reset = 1'b0;
      #1;
      checks += 4;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL mrst out_valid got %b want 0", out_valid); end
      if (date_ok !== 1'b0)   begin errors++; $display("FAIL mrst date_ok got %b want 0", date_ok); end
      if (year !== '0)        begin errors++; $display("FAIL mrst year got %0d want 0", year); end
      if (day !== 5'd0)       begin errors++; $display("FAIL mrst day got %0d want 0", day); end
      @(posedge clk); #1;
      reset = 1'b1;
      model_reset();
      send_str("2022/3/4", 1);
      checks += 5;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL mrst2 out_valid got %b want 1", out_valid); end
      if (year !== YEAR_W'(2022)) begin errors++; $display("FAIL mrst2 year got %0d want 2022", year); end
      if (month !== 4'd3)     begin errors++; $display("FAIL mrst2 month got %0d want 3", month); end
      if (day !== 5'd4)       begin errors++; $display("FAIL mrst2 day got %0d want 4", day); end
      if (date_ok !== 1'b1)   begin errors++; $display("FAIL mrst2 date_ok got %b want 1", date_ok); end
`ifdef DATE_OK_COUNT_EN
      send(" ", 1'b0);
      send(" ", 1'b0);
      checks++;
      if (ok_count !== 16'd1) begin errors++; $display("FAIL mrst ok_count got %0d want 1", ok_count); end
`endif
   endtask

   task automatic test_random();
      string seps = "./-";
      byte   c, s1;
      bit    fv;
      int    yr, mv, dv;
      for (int n = 0; n < 400; n++) begin
         chars.delete();
         yr = $urandom_range(0, 20999);
         if ($urandom_range(0, 9) == 0) push_num(yr % 1000, 3);
         else push_num(yr, (yr > 9999) ? 5 : 4);
         s1 = seps[$urandom_range(0, 2)];
         chars.push_back(s1);
         mv = $urandom_range(0, 14);
         push_num(mv, ($urandom_range(0, 14) == 0) ? 3 : ((mv >= 10 || $urandom_range(0, 3) == 0) ? 2 : 1));
         chars.push_back(($urandom_range(0, 14) == 0) ? seps[$urandom_range(0, 2)] : s1);
         dv = $urandom_range(0, 33);
         push_num(dv, ($urandom_range(0, 14) == 0) ? 3 : ((dv >= 10 || $urandom_range(0, 3) == 0) ? 2 : 1));
         if ($urandom_range(0, 39) == 0) chars[$urandom_range(0, chars.size() - 1)] = "x";
         chars.push_back(($urandom_range(0, 3) == 0) ? byte'("/") : byte'(" "));
         foreach (chars[i]) begin
            c  = chars[i];
            fv = (ms == M_DAY && is_dig(c) && dq.size() < 2) ? 1'b1 : ($urandom_range(0, 24) == 0);
            send(c, fv);
            checks += 6;
            if (out_valid !== e_valid) begin errors++; $display("FAIL rnd out_valid t=%0t got %b want %b", $time, out_valid, e_valid); end
            if (date_ok !== e_ok)      begin errors++; $display("FAIL rnd date_ok t=%0t got %b want %b", $time, date_ok, e_ok); end
            if (year !== YEAR_W'(e_year)) begin errors++; $display("FAIL rnd year t=%0t got %0d want %0d", $time, year, e_year); end
            if (month !== 4'(e_month)) begin errors++; $display("FAIL rnd month t=%0t got %0d want %0d", $time, month, e_month); end
            if (day !== 5'(e_day))     begin errors++; $display("FAIL rnd day t=%0t got %0d want %0d", $time, day, e_day); end
            if (leap !== e_leap)       begin errors++; $display("FAIL rnd leap t=%0t got %b want %b", $time, leap, e_leap); end
         end
      end
      fmt_valid = 1'b0;
`ifdef DATE_OK_COUNT_EN
      send(" ", 1'b0);
      send(" ", 1'b0);
      checks++;
      if (ok_count !== 16'(e_cnt)) begin errors++; $display("FAIL rnd ok_count got %0d want %0d", ok_count, e_cnt); end
`endif
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_mid_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
